bus_keystream_lock: RTL and testbench

Parametrised successor to the fixed 6-bit bus-decoded key-state PAL. The host unlocks the block by writing a programmed sequence of command codes. Once unlocked, each bus read returns one keystream bit from a configurable Fibonacci LFSR. The block adds relock-by-command and an optional read budget that relocks automatically. It sits behind the board address decoder on the shared host bus, one clock domain.

---
 rtl/bus_keystream_lock.sv | 132 +++++++++++++
 tb/tb_bus_keystream_lock.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_keystream_lock.sv
// Host-bus unlock gate: a programmed write sequence unlocks the block, after which
// each read strobe returns one keystream bit from a Fibonacci LFSR.
module bus_keystream_lock #(
    parameter int unsigned                CMD_W      = 4,
    parameter int unsigned                SEQ_LEN    = 4,
    parameter logic [SEQ_LEN*CMD_W-1:0]   SEQ_VALUE  = 16'hC35A,
    parameter logic [CMD_W-1:0]           RELOCK_CMD = 4'hF,
    parameter int unsigned                LFSR_W     = 6,
    parameter logic [LFSR_W-1:0]          LFSR_TAPS  = 6'b110000,
    parameter logic [LFSR_W-1:0]          LFSR_SEED  = 6'b000001,
    parameter int unsigned                MAX_READS  = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sel,
    input  logic                               stb,
    input  logic                               rw,
    input  logic [CMD_W-1:0]                   cmd,
    output logic                               data_out,
    output logic                               data_oe,
    output logic                               unlocked,
    output logic [$clog2(SEQ_LEN+1)-1:0]       seq_idx
);

    localparam int unsigned IDX_W    = $clog2(SEQ_LEN + 1);
    localparam int unsigned CNT_W    = (MAX_READS == 0) ? 1 : $clog2(MAX_READS + 1);
    localparam int unsigned LAST_IDX = SEQ_LEN - 1;
    localparam int unsigned LAST_RD  = (MAX_READS == 0) ? 0 : MAX_READS - 1;
    localparam int unsigned CNT_SAT  = MAX_READS;

    typedef enum logic [0:0] {
        ST_LOCKED   = 1'b0,
        ST_UNLOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    seq_q, seq_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                rd_c;
    logic                wr_c;
    logic                fb_c;
    logic                budget_hit_c;
    logic [CMD_W-1:0]    seq_code_c;
    logic [CMD_W-1:0]    first_code_c;

    assign rd_c         = sel & stb & rw;
    assign wr_c         = sel & stb & ~rw;
    assign fb_c         = ^(lfsr_q & LFSR_TAPS);
    assign first_code_c = SEQ_VALUE[CMD_W-1:0];
    assign budget_hit_c = (MAX_READS != 0) && (cnt_q == CNT_W'(LAST_RD));

    // Expected code at the current match position.
    always_comb begin
        seq_code_c = '0;
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            if (seq_q == IDX_W'(i)) begin
                seq_code_c = SEQ_VALUE[i*CMD_W +: CMD_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOCKED;
            seq_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOCKED: begin
                if (wr_c) begin
                    if (cmd == seq_code_c) begin
                        if (seq_q == IDX_W'(LAST_IDX)) begin
                            state_d = ST_UNLOCKED;
                            seq_d   = '0;
                            lfsr_d  = LFSR_SEED;
                            cnt_d   = '0;
                        end else begin
                            seq_d = seq_q + IDX_W'(1);
                        end
                    end else begin
                        // A mismatching code may itself start a fresh attempt.
                        seq_d = (cmd == first_code_c) ? IDX_W'(1) : '0;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (rd_c) begin
                    lfsr_d = {lfsr_q[LFSR_W-2:0], fb_c};
                    if (cnt_q != CNT_W'(CNT_SAT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (budget_hit_c) begin
                        state_d = ST_LOCKED;
                        seq_d   = '0;
                    end
                end else if (wr_c && (cmd == RELOCK_CMD)) begin
                    state_d = ST_LOCKED;
                    seq_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOCKED;
                seq_d   = '0;
            end
        endcase
        // All-zero LFSR would stick forever; force it back onto the sequence.
        if (lfsr_q == '0) begin
            lfsr_d = LFSR_SEED;
        end
    end

    assign unlocked = (state_q == ST_UNLOCKED);
    assign seq_idx  = seq_q;
    assign data_out = fb_c;
    assign data_oe  = rd_c & unlocked & ~rst;

endmodule

// File: tb/tb_bus_keystream_lock.sv
// Directed bench for bus_keystream_lock: default instance plus a 3-read-budget instance.
module tb_bus_keystream_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       stb = 1'b0;
    logic       rw  = 1'b0;
    logic [3:0] cmd = 4'h0;

    logic       dout_a, oe_a, unl_a;
    logic [2:0] idx_a;
    logic       dout_b, oe_b, unl_b;
    logic [2:0] idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_keystream_lock dut_a (
        .clk(clk), .rst(rst), .sel(sel), .stb(stb), .rw(rw), .cmd(cmd),
        .data_out(dout_a), .data_oe(oe_a), .unlocked(unl_a), .seq_idx(idx_a)
    );

    bus_keystream_lock #(.MAX_READS(3)) dut_b (
        .clk(clk), .rst(rst), .sel(sel), .stb(stb), .rw(rw), .cmd(cmd),
        .data_out(dout_b), .data_oe(oe_b), .unlocked(unl_b), .seq_idx(idx_b)
    );

    typedef struct {
        logic       sel;
        logic       stb;
        logic       rw;
        logic [3:0] cmd;
        logic       e_oe;
        logic       chk_dout;
        logic       e_dout;
        logic       e_unl;
        logic [2:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic st, input logic r, input logic [3:0] c,
                                input logic oe, input logic cd, input logic d,
                                input logic u, input logic [2:0] ix);
        vec_t v;
        v.sel = s; v.stb = st; v.rw = r; v.cmd = c;
        v.e_oe = oe; v.chk_dout = cd; v.e_dout = d; v.e_unl = u; v.e_idx = ix;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an access at the falling edge so it is stable around the next rising edge.
    task automatic drive(input logic s, input logic st, input logic r, input logic [3:0] c);
        @(negedge clk);
        sel = s; stb = st; rw = r; cmd = c;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        sel = 1'b0; stb = 1'b0; rw = 1'b0; cmd = 4'h0;
    endtask

    task automatic do_write(input logic [3:0] c);
        drive(1'b1, 1'b1, 1'b0, c);
        edge_wait();
    endtask

    task automatic unlock_seq();
        do_write(4'hA); do_write(4'h5); do_write(4'h3); do_write(4'hC);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; stb = 1'b0; rw = 1'b0; cmd = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] m;
        logic       eb;

        // Unlock, reads, ignored write, stray strobe, relock, restart, mismatch.
        vecs.push_back(mk(1,1,1,4'h0, 0,0,0, 0,3'd0));
        vecs.push_back(mk(1,1,0,4'hA, 0,0,0, 0,3'd1));
        vecs.push_back(mk(1,1,0,4'h5, 0,0,0, 0,3'd2));
        vecs.push_back(mk(1,1,0,4'h3, 0,0,0, 0,3'd3));
        vecs.push_back(mk(1,1,0,4'hC, 0,0,0, 1,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 1,1,0, 1,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 1,1,0, 1,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 1,1,0, 1,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 1,1,0, 1,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 1,1,1, 1,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 1,1,1, 1,3'd0));
        vecs.push_back(mk(1,1,0,4'h2, 0,0,0, 1,3'd0));
        vecs.push_back(mk(0,1,0,4'hF, 0,0,0, 1,3'd0));
        vecs.push_back(mk(0,1,1,4'h0, 0,0,0, 1,3'd0));
        vecs.push_back(mk(1,1,0,4'hF, 0,0,0, 0,3'd0));
        vecs.push_back(mk(1,1,1,4'h0, 0,0,0, 0,3'd0));
        vecs.push_back(mk(1,1,0,4'hA, 0,0,0, 0,3'd1));
        vecs.push_back(mk(1,1,0,4'h5, 0,0,0, 0,3'd2));
        vecs.push_back(mk(1,1,0,4'hA, 0,0,0, 0,3'd1));
        vecs.push_back(mk(1,1,0,4'h5, 0,0,0, 0,3'd2));
        vecs.push_back(mk(1,1,0,4'h3, 0,0,0, 0,3'd3));
        vecs.push_back(mk(1,1,0,4'hC, 0,0,0, 1,3'd0));
        vecs.push_back(mk(1,1,0,4'hF, 0,0,0, 0,3'd0));
        vecs.push_back(mk(1,1,0,4'hA, 0,0,0, 0,3'd1));
        vecs.push_back(mk(1,1,0,4'h5, 0,0,0, 0,3'd2));
        vecs.push_back(mk(1,1,0,4'h7, 0,0,0, 0,3'd0));

        do_reset();
        #1;
        check("reset_unlocked", 32'(unl_a), 32'd0);
        check("reset_seq_idx",  32'(idx_a), 32'd0);
        check("reset_oe",       32'(oe_a),  32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].stb, vecs[i].rw, vecs[i].cmd);
            check($sformatf("vec%0d_oe", i), 32'(oe_a), 32'(vecs[i].e_oe));
            if (vecs[i].chk_dout) begin
                check($sformatf("vec%0d_dout", i), 32'(dout_a), 32'(vecs[i].e_dout));
            end
            edge_wait();
            check($sformatf("vec%0d_unlocked", i), 32'(unl_a), 32'(vecs[i].e_unl));
            check($sformatf("vec%0d_seq_idx", i),  32'(idx_a), 32'(vecs[i].e_idx));
        end
        idle();

        // Full LFSR period against a bench-side model of the taps.
        do_reset();
        unlock_seq();
        check("period_unlocked", 32'(unl_a), 32'd1);
        m = 6'b000001;
        for (int i = 0; i < 63; i++) begin
            eb = m[5] ^ m[4];
            drive(1'b1, 1'b1, 1'b1, 4'h0);
            check($sformatf("period_bit%0d", i), 32'(dout_a), 32'(eb));
            edge_wait();
            m = {m[4:0], eb};
        end
        idle();
        check("period_lfsr_back_to_seed", 32'(dut_a.lfsr_q), 32'd1);

        // Read budget of 3 on the second instance.
        do_reset();
        unlock_seq();
        check("budget_unlocked", 32'(unl_b), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'h0);
            check($sformatf("budget_oe%0d", i),   32'(oe_b),   32'd1);
            check($sformatf("budget_dout%0d", i), 32'(dout_b), 32'd0);
            edge_wait();
            check($sformatf("budget_unl%0d", i),  32'(unl_b),  (i < 2) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 1'b1, 1'b1, 4'h0);
        check("budget_4th_oe", 32'(oe_b), 32'd0);
        edge_wait();
        check("budget_still_locked", 32'(unl_b), 32'd0);
        idle();
        unlock_seq();
        check("budget_relock_unl",  32'(unl_b), 32'd1);
        check("budget_relock_seed", 32'(dut_b.lfsr_q), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'h0);
            check($sformatf("budget2_dout%0d", i), 32'(dout_b), 32'd0);
            edge_wait();
        end
        idle();
        check("budget2_locked", 32'(unl_b), 32'd0);

        // Asynchronous reset mid-sequence.
        do_reset();
        do_write(4'hA); do_write(4'h5);
        check("async_pre_idx", 32'(idx_a), 32'd2);
        idle();
        #2 rst = 1'b1;
        #1;
        check("async_seq_unl", 32'(unl_a), 32'd0);
        check("async_seq_idx", 32'(idx_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a read strobe.
        unlock_seq();
        drive(1'b1, 1'b1, 1'b1, 4'h0); edge_wait();
        drive(1'b1, 1'b1, 1'b1, 4'h0); edge_wait();
        drive(1'b1, 1'b1, 1'b1, 4'h0);
        check("async_rd_oe_before", 32'(oe_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rd_oe",   32'(oe_a),  32'd0);
        check("async_rd_unl",  32'(unl_a), 32'd0);
        check("async_rd_idx",  32'(idx_a), 32'd0);
        check("async_rd_lfsr", 32'(dut_a.lfsr_q), 32'd1);
        idle();
        rst = 1'b0;
        #1;
        check("post_reset_locked", 32'(unl_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
